// File: rtl/info_slot_table.sv
// ============================================================================
// Module   : info_slot_table
// Purpose  : Per-warp memory request context table; lowest-free allocation,
//            release by index, combinational read. Optional age timeout when
//            INFO_SLOT_TIMEOUT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module info_slot_table #(
    parameter int DEPTH          = 32,
    parameter int DEPTH_LOG      = 5,
    parameter int INFO_W         = 16,
    parameter int LANES          = 8,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int AFULL_THRESH   = 28,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall_i,
    input  logic                      alloc_valid_i,
    input  logic [INFO_W-1:0]         alloc_info_i,
    input  logic [LANES*ADDR_W-1:0]   alloc_addr_i,
    input  logic [LANES*DATA_W-1:0]   alloc_data_i,
    output logic                      alloc_ready_o,
    output logic [DEPTH_LOG-1:0]      alloc_slot_o,
    input  logic                      free_valid_i,
    input  logic [DEPTH_LOG-1:0]      free_slot_i,
    input  logic [DEPTH_LOG-1:0]      rd_slot_i,
    output logic                      rd_valid_o,
    output logic [INFO_W-1:0]         rd_info_o,
    output logic [LANES*ADDR_W-1:0]   rd_addr_o,
    output logic [LANES*DATA_W-1:0]   rd_data_o,
    output logic [DEPTH_LOG:0]        count_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic                      afull_o,
    output logic                      err_double_free_o,
    output logic                      timeout_o,
    output logic [DEPTH_LOG-1:0]      timeout_slot_o
);

    localparam logic [DEPTH_LOG:0] c_depth = (DEPTH_LOG+1)'(DEPTH);

    logic [DEPTH-1:0]          r_valid;
    logic [DEPTH_LOG:0]        r_count;
    logic                      r_err;

    logic [INFO_W-1:0]         r_info_mem [DEPTH];
    logic [LANES*ADDR_W-1:0]   r_addr_mem [DEPTH];
    logic [LANES*DATA_W-1:0]   r_data_mem [DEPTH];

    logic [DEPTH_LOG-1:0]      w_alloc_slot;
    logic                      w_full;
    logic                      w_alloc_acc;
    logic                      w_free_acc;
    logic                      w_free_hit;
    logic                      w_free_miss;

    // Scan from the top so the last assignment wins with the lowest free index.
    always_comb begin
        w_alloc_slot = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_alloc_slot = DEPTH_LOG'(i);
            end
        end
    end

    assign w_full      = (r_count == c_depth);
    assign w_alloc_acc = alloc_valid_i & ~w_full & ~stall_i;
    assign w_free_acc  = free_valid_i & ~stall_i;
    assign w_free_hit  = w_free_acc & r_valid[free_slot_i];
    assign w_free_miss = w_free_acc & ~r_valid[free_slot_i];

    // Allocated slot is always invalid and a hit release is always valid,
    // so the two updates never target the same bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_alloc_acc) begin
                r_valid[w_alloc_slot] <= 1'b1;
            end
            if (w_free_hit) begin
                r_valid[free_slot_i] <= 1'b0;
            end
            r_count <= r_count + (DEPTH_LOG+1)'(w_alloc_acc) - (DEPTH_LOG+1)'(w_free_hit);
            if (w_free_miss) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_alloc_acc) begin
            r_info_mem[w_alloc_slot] <= alloc_info_i;
            r_addr_mem[w_alloc_slot] <= alloc_addr_i;
            r_data_mem[w_alloc_slot] <= alloc_data_i;
        end
    end

    assign alloc_ready_o     = ~w_full;
    assign alloc_slot_o      = w_alloc_slot;
    assign count_o           = r_count;
    assign full_o            = w_full;
    assign empty_o           = (r_count == '0);
    assign afull_o           = (32'(r_count) >= 32'(AFULL_THRESH));
    assign err_double_free_o = r_err;

    assign rd_valid_o = r_valid[rd_slot_i];
    assign rd_info_o  = r_info_mem[rd_slot_i];
    assign rd_addr_o  = r_addr_mem[rd_slot_i];
    assign rd_data_o  = r_data_mem[rd_slot_i];

`ifdef INFO_SLOT_TIMEOUT_EN
    localparam int c_age_w = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_age_w-1:0] c_age_max = c_age_w'(TIMEOUT_CYCLES);

    logic [c_age_w-1:0]   r_age [DEPTH];
    logic [DEPTH-1:0]     w_expired;
    logic                 w_timeout;
    logic [DEPTH_LOG-1:0] w_timeout_slot;

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_age
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_age[g] <= '0;
                end else if (w_alloc_acc && (w_alloc_slot == DEPTH_LOG'(g))) begin
                    r_age[g] <= '0;
                end else if (!stall_i && r_valid[g] && (r_age[g] != c_age_max)) begin
                    r_age[g] <= r_age[g] + 1'b1;
                end
            end
            assign w_expired[g] = r_valid[g] & (r_age[g] == c_age_max);
        end
    endgenerate

    always_comb begin
        w_timeout_slot = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_expired[i]) begin
                w_timeout_slot = DEPTH_LOG'(i);
            end
        end
    end

    assign w_timeout      = |w_expired;
    assign timeout_o      = w_timeout;
    assign timeout_slot_o = w_timeout_slot;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign timeout_o        = 1'b0;
    assign timeout_slot_o   = '0;
`endif

endmodule

`default_nettype wire
